// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the serial sequence-detector controller.
//   state_t      : controller FSM encoding (IDLE/SHIFT/WAIT/DONE, 2 bits)
//   DEF_*        : default widths used by the controller and matcher
package seq_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PAT_W  = 5;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pattern_matcher.sv
// Bit-serial overlapping pattern matcher.
//   clk, reset  : clock, asynchronous active-low reset
//   clear       : synchronous clear of history, fill count and match
//   bit_valid   : shift bit_in into the history this cycle
//   bit_in      : serial bit, newest
//   pattern     : pattern to detect, bit PAT_W-1 is the oldest bit
//   match       : registered 1-cycle pulse, the cycle after the completing bit
module pattern_matcher
  import seq_ctrl_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  history;
  logic [PAT_W-1:0]  history_next;
  logic [FILL_W-1:0] fill;

  assign history_next = (history << 1) | PAT_W'(bit_in);

  // The fill count stops the all-zero reset history from matching an
  // all-zero pattern before PAT_W real bits have arrived.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      history <= '0;
      fill    <= '0;
      match   <= 1'b0;
    end else if (clear) begin
      history <= '0;
      fill    <= '0;
      match   <= 1'b0;
    end else if (bit_valid) begin
      history <= history_next;
      if (fill != FILL_W'(PAT_W)) fill <= fill + 1'b1;
      match   <= (history_next == pattern) && (fill >= FILL_W'(PAT_W - 1));
    end else begin
      match <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Controller for the serial sequence detector: takes parallel words over a
// valid/ready handshake, serializes them MSB first into pattern_matcher,
// counts matches (saturating) and raises a sticky irq at a threshold.
//   cfg_we/cfg_pattern/cfg_threshold/cfg_err : configuration, only while idle
//   s_valid/s_ready/s_data/s_last            : upstream word stream
//   ser_bit/ser_valid                        : bit presented to the matcher
//   match/match_count/frame_done/irq/irq_clr : results and interrupt
//   busy                                     : FSM not idle
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [CNT_W-1:0]  cfg_threshold,
  output logic              cfg_err,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              frame_done,
  output logic              irq,
  input  logic              irq_clr,
  output logic              busy
);

  localparam int IDX_W = $clog2(DATA_W);

  state_t            state;
  logic [DATA_W-1:0] word;
  logic              word_last;
  logic [IDX_W-1:0]  idx;
  logic [PAT_W-1:0]  pattern;
  logic [CNT_W-1:0]  threshold;

  logic handshake;
  logic cfg_accept;
  logic last_bit;
  logic count_inc;
  logic irq_hit;

  assign last_bit   = (idx == '0);
  // Ready at the final bit of a non-final word so a frame streams without gaps.
  assign s_ready    = (state == IDLE) || (state == WAIT) ||
                      ((state == SHIFT) && last_bit && !word_last);
  assign handshake  = s_valid && s_ready;
  assign busy       = (state != IDLE);
  assign cfg_accept = cfg_we && (state == IDLE);

  // Only a real increment can hit the threshold, so saturation never re-arms irq.
  assign count_inc  = match && (match_count != '1);
  assign irq_hit    = count_inc && (threshold != '0) &&
                      ((match_count + CNT_W'(1)) == threshold);

  // ser_bit is loaded one edge ahead: the first bit of an accepted word is
  // already on the output in the first SHIFT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      word       <= '0;
      word_last  <= 1'b0;
      idx        <= '0;
      ser_bit    <= 1'b0;
      ser_valid  <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cfg_err    <= cfg_we && (state != IDLE);
      case (state)
        IDLE, WAIT: begin
          ser_valid <= 1'b0;
          if (handshake) begin
            state     <= SHIFT;
            word      <= s_data;
            word_last <= s_last;
            idx       <= IDX_W'(DATA_W - 1);
            ser_bit   <= s_data[DATA_W-1];
            ser_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            idx       <= idx - 1'b1;
            ser_bit   <= word[idx - 1'b1];
            ser_valid <= 1'b1;
          end else if (word_last) begin
            state      <= DONE;
            ser_valid  <= 1'b0;
            frame_done <= 1'b1;
          end else if (handshake) begin
            word      <= s_data;
            word_last <= s_last;
            idx       <= IDX_W'(DATA_W - 1);
            ser_bit   <= s_data[DATA_W-1];
            ser_valid <= 1'b1;
          end else begin
            state     <= WAIT;
            ser_valid <= 1'b0;
          end
        end
        DONE: begin
          state     <= IDLE;
          ser_valid <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          ser_valid <= 1'b0;
        end
      endcase
    end
  end

  // Configuration, saturating match counter and sticky irq (set beats clear).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern     <= '0;
      threshold   <= '0;
      match_count <= '0;
      irq         <= 1'b0;
    end else if (cfg_accept) begin
      pattern     <= cfg_pattern;
      threshold   <= cfg_threshold;
      match_count <= '0;
      irq         <= 1'b0;
    end else begin
      if (count_inc) match_count <= match_count + CNT_W'(1);
      if (irq_hit)      irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
    end
  end

  pattern_matcher #(
    .PAT_W(PAT_W)
  ) u_matcher (
    .clk      (clk),
    .reset    (reset),
    .clear    ((state == DONE) || cfg_accept),
    .bit_valid(ser_valid),
    .bit_in   (ser_bit),
    .pattern  (pattern),
    .match    (match)
  );

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed frames plus randomized
// frames, with a bit-level reference model feeding a scoreboard that a
// negedge monitor drains.
module tb_seq_detect_ctrl;

  localparam int DATA_W  = 8;
  localparam int PAT_W   = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              reset;
  logic              cfg_we;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [CNT_W-1:0]  cfg_threshold;
  logic              cfg_err;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              ser_bit;
  logic              ser_valid;
  logic              match;
  logic [CNT_W-1:0]  match_count;
  logic              frame_done;
  logic              irq;
  logic              irq_clr;
  logic              busy;

  int checks = 0;
  int fails  = 0;

  // scoreboard: filled by stimulus, drained by monitor
  bit expBits[$];
  bit expMatch[$];
  bit expFrames[$];

  // reference model state owned by stimulus
  bit               hist[$];
  logic [PAT_W-1:0] modelPattern;
  bit               cfgExpectAccept;

  // reference model state owned by monitor
  int  expCount;
  bit  expIrq;
  int  thr;
  bit  pendMatch;
  bit  pendCfgErr;
  int  runLen;
  int  lastRun;

  seq_detect_ctrl #(
    .DATA_W(DATA_W),
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_we       (cfg_we),
    .cfg_pattern  (cfg_pattern),
    .cfg_threshold(cfg_threshold),
    .cfg_err      (cfg_err),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .ser_bit      (ser_bit),
    .ser_valid    (ser_valid),
    .match        (match),
    .match_count  (match_count),
    .frame_done   (frame_done),
    .irq          (irq),
    .irq_clr      (irq_clr),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected serial bits and match flags for one word, from a sliding
  // window of the bits seen since the last history clear.
  task automatic pushWord(input logic [DATA_W-1:0] d, input bit last);
    bit b;
    bit m;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      b = d[i];
      hist.push_back(b);
      if (hist.size() > PAT_W) void'(hist.pop_front());
      m = 0;
      if (hist.size() == PAT_W) begin
        m = 1;
        for (int k = 0; k < PAT_W; k++)
          if (hist[k] != modelPattern[PAT_W-1-k]) m = 0;
      end
      expBits.push_back(b);
      expMatch.push_back(m);
    end
    if (last) begin
      expFrames.push_back(1'b1);
      hist.delete();
    end
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] d, input bit last);
    int n;
    bit got;
    n = 0;
    got = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!got && n < 50) begin
      @(negedge clk);
      if (s_ready) got = 1;
      else n++;
    end
    checkOutput("handshake_wait", 32'(got), 1);
    if (got) pushWord(d, last);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic applyCfg(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] t);
    cfg_we          = 1'b1;
    cfg_pattern     = p;
    cfg_threshold   = t;
    cfgExpectAccept = 1'b1;
    modelPattern    = p;
    hist.delete();
    @(posedge clk); #1;
    cfg_we          = 1'b0;
    cfgExpectAccept = 1'b0;
  endtask

  task automatic busyCfgPoke(input logic [PAT_W-1:0] p);
    cfg_we          = 1'b1;
    cfg_pattern     = p;
    cfg_threshold   = CNT_W'($urandom);
    cfgExpectAccept = 1'b0;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    checkOutput("idle_wait", 32'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic pulseIrqClr();
    irq_clr = 1'b1;
    @(posedge clk); #1;
    irq_clr = 1'b0;
  endtask

  // Monitor: compares every cycle against the scoreboard and advances the
  // count/irq model for the coming edge.
  always @(negedge clk) begin
    bit b;
    bit m;
    bit nextPend;
    bit setIrq;
    if (!reset) begin
      expBits.delete();
      expMatch.delete();
      expFrames.delete();
      expCount   = 0;
      expIrq     = 0;
      thr        = 0;
      pendMatch  = 0;
      pendCfgErr = 0;
      runLen     = 0;
    end else begin
      checkOutput("match", 32'(match), 32'(pendMatch));
      checkOutput("match_count", 32'(match_count), 32'(expCount));
      checkOutput("irq", 32'(irq), 32'(expIrq));
      checkOutput("cfg_err", 32'(cfg_err), 32'(pendCfgErr));
      if (frame_done) begin
        checkOutput("frame_done_expected", 32'(expFrames.size() != 0), 1);
        if (expFrames.size() != 0) void'(expFrames.pop_front());
      end
      nextPend = 0;
      if (ser_valid) begin
        runLen++;
        checkOutput("ser_valid_expected", 32'(expBits.size() != 0), 1);
        if (expBits.size() != 0) begin
          b = expBits.pop_front();
          m = expMatch.pop_front();
          checkOutput("ser_bit", 32'(ser_bit), 32'(b));
          nextPend = m;
        end
      end else if (runLen != 0) begin
        lastRun = runLen;
        runLen  = 0;
      end
      if (cfg_we && cfgExpectAccept) begin
        expCount = 0;
        expIrq   = 0;
        thr      = int'(cfg_threshold);
      end else begin
        setIrq = 0;
        if (pendMatch && expCount != CNT_MAX) begin
          expCount++;
          if (thr != 0 && expCount == thr) setIrq = 1;
        end
        if (setIrq) expIrq = 1;
        else if (irq_clr) expIrq = 0;
      end
      pendMatch  = nextPend;
      pendCfgErr = cfg_we && !cfgExpectAccept;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0]  d;
    logic [2*PAT_W-1:0] dbl;
    int nw;
    int gap;

    reset = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_threshold = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; irq_clr = 1'b0;
    cfgExpectAccept = 1'b0; modelPattern = '0; lastRun = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_s_ready", 32'(s_ready), 1);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_ser_valid", 32'(ser_valid), 0);
    checkOutput("rst_match_count", 32'(match_count), 0);
    checkOutput("rst_irq", 32'(irq), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: single word, two overlapping matches, irq at threshold 2
    $display("[TB] directed 1: overlapping matches in one word");
    applyCfg(5'b11011, 4'd2);
    applyStimulus(8'b11011011, 1'b1);
    waitIdle();
    checkOutput("t1_count", 32'(match_count), 2);
    checkOutput("t1_irq", 32'(irq), 1);

    // 2: match spanning a word boundary, gapless 16-bit run
    $display("[TB] directed 2: match across word boundary");
    applyCfg(5'b11011, 4'd0);
    applyStimulus(8'b00000110, 1'b0);
    applyStimulus(8'b11000000, 1'b1);
    waitIdle();
    checkOutput("t2_count", 32'(match_count), 1);
    checkOutput("t2_run_len", 32'(lastRun), 16);

    // 3: frame boundary clears history
    $display("[TB] directed 3: history cleared between frames");
    applyCfg(5'b11011, 4'd0);
    applyStimulus(8'b00000110, 1'b1);
    applyStimulus(8'b11000000, 1'b1);
    waitIdle();
    checkOutput("t3_count", 32'(match_count), 0);

    // 4: cfg while busy ignored; irq set wins over same-cycle irq_clr
    $display("[TB] directed 4: busy cfg write and irq set/clear race");
    applyCfg(5'b11011, 4'd1);
    applyStimulus(8'b11011011, 1'b1);
    busyCfgPoke(5'b11111);
    begin
      int n;
      n = 0;
      while (!match && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      checkOutput("t4_match_seen", 32'(match), 1);
      irq_clr = 1'b1;
      @(posedge clk); #1;
      irq_clr = 1'b0;
      checkOutput("t4_irq_set_wins", 32'(irq), 1);
    end
    waitIdle();
    checkOutput("t4_count", 32'(match_count), 2);
    pulseIrqClr();
    checkOutput("t4_irq_cleared", 32'(irq), 0);

    // 5: saturation at CNT_MAX, irq not re-set after clear
    $display("[TB] directed 5: counter saturation");
    applyCfg(5'b11111, 4'(CNT_MAX));
    for (int w = 0; w < 4; w++) applyStimulus(8'hFF, w == 3);
    checkOutput("t5_irq_set", 32'(irq), 1);
    pulseIrqClr();
    waitIdle();
    checkOutput("t5_count_sat", 32'(match_count), CNT_MAX);
    checkOutput("t5_irq_stays_clear", 32'(irq), 0);

    // 6: reset mid-frame, then a normal frame
    $display("[TB] directed 6: reset during SHIFT");
    applyCfg(5'b11011, 4'd2);
    applyStimulus(8'b11011011, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    hist.delete();
    modelPattern = '0;
    #1;
    checkOutput("t6_s_ready", 32'(s_ready), 1);
    checkOutput("t6_busy", 32'(busy), 0);
    checkOutput("t6_ser_valid", 32'(ser_valid), 0);
    checkOutput("t6_count", 32'(match_count), 0);
    checkOutput("t6_frame_done", 32'(frame_done), 0);
    checkOutput("t6_match", 32'(match), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    applyCfg(5'b11011, 4'd2);
    applyStimulus(8'b11011011, 1'b1);
    waitIdle();
    checkOutput("t6_count_after", 32'(match_count), 2);
    checkOutput("t6_irq_after", 32'(irq), 1);

    // randomized frames with gaps, irq_clr noise and busy cfg writes
    $display("[TB] random frames");
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 2) == 0) applyCfg(PAT_W'($urandom), CNT_W'($urandom));
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
        repeat (gap) begin @(posedge clk); #1; end
        irq_clr = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 1) == 1) begin
          d = DATA_W'($urandom);
        end else begin
          dbl = {modelPattern, modelPattern};
          d = DATA_W'(dbl >> $urandom_range(0, PAT_W - 1));
        end
        applyStimulus(d, w == nw - 1);
        irq_clr = 1'b0;
        if ($urandom_range(0, 5) == 0) busyCfgPoke(PAT_W'($urandom));
      end
      waitIdle();
    end

    repeat (3) begin @(posedge clk); #1; end
    checkOutput("bits_drained", 32'(expBits.size()), 0);
    checkOutput("frames_drained", 32'(expFrames.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
